// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, feeder state type and lane helpers
// for the systolic feeder slice.
package systolic_pkg;

    localparam int NLANES_D = 3;
    localparam int NBITS_D  = 16;
    localparam int LENW_D   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } feed_state_t;

    // Low bit of a lane's slice inside a packed lane bus.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/systolic_delay_line.sv
// systolic_delay_line: DEPTH enabled stages carrying data plus valid.
// Ports: clk, i_rst_n (async low), i_en, i_valid/i_data in,
//        o_valid/o_data from the last stage.
module systolic_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] r_v;
    logic [W-1:0]     r_d   [DEPTH];
    logic [DEPTH-1:0] w_vin;
    logic [W-1:0]     w_din [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_vin[k] = i_valid;
            assign w_din[k] = i_data;
        end else begin : g_tail
            assign w_vin[k] = r_v[k-1];
            assign w_din[k] = r_d[k-1];
        end
    end

    // Data only moves with a valid word, so an invalid slot keeps
    // the previous valid value and the bus does not toggle.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_v[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_d[k] <= w_din[k];
                end
            end
        end
    end

    assign o_valid = r_v[DEPTH-1];
    assign o_data  = r_d[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: drains NLANES FIFOs in lock-step and presents a
// diagonally skewed wavefront (lane i delayed i cycles) to the array.
// Ports: clk, rst (async low), start/len block request, busy/done status,
//        fifo_ren/fifo_empty/fifo_q FIFO side, stall backpressure,
//        arr_data/arr_val skewed array side.
// Macro SYSTOLIC_FEEDER_ZERO_FILL_EN: drive zeros on invalid lane slots
// instead of holding the last valid word.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int NLANES = NLANES_D,
    parameter int nbits  = NBITS_D,
    parameter int LENW   = LENW_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LENW-1:0]         len,
    output logic                    busy,
    output logic                    done,
    output logic [NLANES-1:0]       fifo_ren,
    input  logic [NLANES-1:0]       fifo_empty,
    input  logic [NLANES*nbits-1:0] fifo_q,
    input  logic                    stall,
    output logic [NLANES*nbits-1:0] arr_data,
    output logic [NLANES-1:0]       arr_val
);

    localparam int CNTW = $clog2(NLANES + 1);

    feed_state_t     r_state;
    feed_state_t     w_state_nxt;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] w_len_nxt;
    logic [LENW-1:0] r_issued;
    logic [LENW-1:0] w_issued_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_pend;
    logic            w_ren;
    logic            w_all_rdy;

    logic [NLANES-1:0] w_val;
    logic [nbits-1:0]  w_dat [NLANES];

    assign w_all_rdy = &(~fifo_empty);

    // A pending word is always consumed in any non-stalled cycle, so a
    // new read can be issued in the same cycle the old one is captured.
    assign w_ren = (r_state == S_FEED) && w_all_rdy && !stall
                && (r_issued < r_len);

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_issued_nxt = r_issued;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt    = len;
                    w_issued_nxt = '0;
                    if (len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end
            end
            S_FEED: begin
                if (w_ren) begin
                    w_issued_nxt = r_issued + 1'b1;
                end else if ((r_issued == r_len) && !r_pend) begin
                    // Last word sits in stage 0; it needs NLANES more
                    // advances, one of which may happen this cycle.
                    w_cnt_nxt = stall ? CNTW'(NLANES) : CNTW'(NLANES - 1);
                    if (w_cnt_nxt == '0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (r_cnt <= CNTW'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_issued <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_issued <= w_issued_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_pend   <= w_ren | (r_pend & stall);
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        systolic_delay_line #(
            .DEPTH (g + 1),
            .W     (nbits)
        ) u_dl (
            .clk     (clk),
            .i_rst_n (rst),
            .i_en    (!stall),
            .i_valid (r_pend),
            .i_data  (fifo_q[lane_lo(g, nbits) +: nbits]),
            .o_valid (w_val[g]),
            .o_data  (w_dat[g])
        );
`ifdef SYSTOLIC_FEEDER_ZERO_FILL_EN
        assign arr_data[lane_lo(g, nbits) +: nbits] =
            w_val[g] ? w_dat[g] : '0;
`else
        assign arr_data[lane_lo(g, nbits) +: nbits] = w_dat[g];
`endif
    end

    assign arr_val  = w_val;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign fifo_ren = {NLANES{w_ren}};

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed table, hand sequences and random blocks
// checked against a timing-rule reference model.
module tb_systolic_feeder;

    localparam int NL = 3;
    localparam int NB = 16;
    localparam int LW = 8;
    localparam int NC = 64;
`ifdef SYSTOLIC_FEEDER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LW-1:0]    len = '0;
    logic             busy;
    logic             done;
    logic [NL-1:0]    fifo_ren;
    logic [NL-1:0]    fifo_empty = '1;
    logic [NL*NB-1:0] fifo_q = '0;
    logic             stall = 1'b0;
    logic [NL*NB-1:0] arr_data;
    logic [NL-1:0]    arr_val;

    systolic_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_ren   (fifo_ren),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .stall      (stall),
        .arr_data   (arr_data),
        .arr_val    (arr_val)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    logic [NB-1:0] fq [NL][$];
    logic [NB-1:0] mq [NL][$];

    bit            st_start [NC];
    logic [LW-1:0] st_len   [NC];
    bit            st_stall [NC];
    logic [NL-1:0] st_force [NC];

    bit               e_ren  [NC];
    bit               e_done [NC];
    bit               e_busy [NC];
    logic [NL-1:0]    e_val  [NC];
    logic [NL*NB-1:0] e_data [NC];

    logic [NL-1:0]    l_ren  [NC];
    logic             l_done [NC];
    logic             l_busy [NC];
    logic [NL-1:0]    l_val  [NC];
    logic [NL*NB-1:0] l_data [NC];

    logic [NL-1:0]    s_ren;
    logic             s_done;
    logic             s_busy;
    logic [NL-1:0]    s_val;
    logic [NL*NB-1:0] s_data;

    typedef struct {
        string       name;
        int          len;
        int          st_lo;
        int          st_hi;
        int          sv_lo;
        int          sv_hi;
        int          s2_cyc;
        int          s2_len;
        int          exp_done;
        logic [15:0] exp_ren;
        int          chk_c;
        int          chk_lane;
        logic        chk_v;
        logic [15:0] chk_d;
    } vec_t;

    vec_t tbl [5];

    task automatic cmp(string nm, int c, logic [63:0] got,
                       logic [63:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                      nm, c, got, want);
    endtask

    task automatic drive_empty(logic [NL-1:0] force_m);
        for (int i = 0; i < NL; i++)
            fifo_empty[i] = (fq[i].size() == 0) || force_m[i];
    endtask

    task automatic tick();
        @(negedge clk);
        s_ren  = fifo_ren;
        s_done = done;
        s_busy = busy;
        s_val  = arr_val;
        s_data = arr_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++)
            if (s_ren[i] && fq[i].size() > 0)
                fifo_q[i*NB +: NB] = fq[i].pop_front();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        len = '0;
        fifo_q = '0;
        fifo_empty = '1;
        for (int i = 0; i < NL; i++) fq[i].delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < NC; c++) begin
            st_start[c] = 1'b0;
            st_len[c]   = '0;
            st_stall[c] = 1'b0;
            st_force[c] = '0;
        end
    endtask

    // Cycle of the n-th non-stalled cycle at or after t.
    function automatic int nth_ns(int t, int n);
        int k = 0;
        for (int c = t; c < NC; c++) begin
            if (!st_stall[c]) begin
                k++;
                if (k == n) return c;
            end
        end
        return NC + 100;
    endfunction

    // Reference: a read issued in cycle t reaches lane i's output after
    // its (i+2)-th non-stalled cycle; done follows the (NL+2)-th.
    task automatic build_model(int nc);
        int idle_from = 0;
        bit act = 1'b0;
        int fs = 0;
        int iss = 0;
        int ml = 0;
        int vt[$];
        logic [NL*NB-1:0] vd[$];
        for (int c = 0; c < NC; c++) begin
            e_ren[c]  = 1'b0;
            e_done[c] = 1'b0;
            e_busy[c] = 1'b0;
            e_val[c]  = '0;
            e_data[c] = '0;
        end
        for (int i = 0; i < NL; i++) mq[i] = fq[i];
        for (int c = 0; c < nc; c++) begin
            bit avail = 1'b1;
            if (c >= idle_from && st_start[c]) begin
                if (st_len[c] == 0) begin
                    if (c + 1 < NC) e_done[c+1] = 1'b1;
                end else begin
                    act = 1'b1;
                    fs = c + 1;
                    iss = 0;
                    ml = int'(st_len[c]);
                    idle_from = 1 << 30;
                end
            end
            for (int i = 0; i < NL; i++)
                if (mq[i].size() == 0 || st_force[c][i]) avail = 1'b0;
            if (act && c >= fs && iss < ml && !st_stall[c] && avail) begin
                logic [NL*NB-1:0] w;
                int d;
                w = '0;
                for (int i = 0; i < NL; i++)
                    w[i*NB +: NB] = mq[i].pop_front();
                e_ren[c] = 1'b1;
                vt.push_back(c);
                vd.push_back(w);
                iss++;
                if (iss == ml) begin
                    d = nth_ns(c, NL + 2) + 1;
                    if (d < NC) e_done[d] = 1'b1;
                    for (int b = fs; b < d && b < NC; b++) e_busy[b] = 1'b1;
                    idle_from = d;
                    act = 1'b0;
                end
            end
        end
        if (act)
            for (int b = fs; b < NC; b++) e_busy[b] = 1'b1;
        for (int i = 0; i < NL; i++) begin
            logic v = 1'b0;
            logic [NB-1:0] dd = '0;
            for (int c = 0; c < nc; c++) begin
                e_val[c][i] = v;
                e_data[c][i*NB +: NB] = (ZF && !v) ? '0 : dd;
                if (!st_stall[c]) begin
                    v = 1'b0;
                    for (int k = 0; k < vt.size(); k++) begin
                        if (nth_ns(vt[k], i + 2) == c) begin
                            v = 1'b1;
                            dd = vd[k][i*NB +: NB];
                        end
                    end
                end
            end
        end
    endtask

    task automatic run(int nc);
        for (int c = 0; c < nc; c++) begin
            start = st_start[c];
            len   = st_len[c];
            stall = st_stall[c];
            drive_empty(st_force[c]);
            tick();
            l_ren[c]  = s_ren;
            l_done[c] = s_done;
            l_busy[c] = s_busy;
            l_val[c]  = s_val;
            l_data[c] = s_data;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic compare_all(int nc, string tag);
        for (int c = 0; c < nc; c++) begin
            cmp({tag, "_ren"}, c, 64'(l_ren[c]), 64'({NL{e_ren[c]}}));
            cmp({tag, "_done"}, c, 64'(l_done[c]), 64'(e_done[c]));
            cmp({tag, "_busy"}, c, 64'(l_busy[c]), 64'(e_busy[c]));
            cmp({tag, "_val"}, c, 64'(l_val[c]), 64'(e_val[c]));
            cmp({tag, "_data"}, c, 64'(l_data[c]), 64'(e_data[c]));
        end
    endtask

    function automatic vec_t mk(string nm, int ln, int slo, int shi,
                                int vlo, int vhi, int s2c, int s2l,
                                int ed, logic [15:0] er, int cc, int cl,
                                logic cv, logic [15:0] cd);
        vec_t v;
        v.name = nm; v.len = ln; v.st_lo = slo; v.st_hi = shi;
        v.sv_lo = vlo; v.sv_hi = vhi; v.s2_cyc = s2c; v.s2_len = s2l;
        v.exp_done = ed; v.exp_ren = er; v.chk_c = cc; v.chk_lane = cl;
        v.chk_v = cv; v.chk_d = cd;
        return v;
    endfunction

    initial begin
        tbl[0] = mk("basic", 4, -1, -1, -1, -1, -1, 0,
                    9, 16'h001E, 8, 2, 1'b1, 16'd24);
        tbl[1] = mk("stall", 4, 4, 5, -1, -1, -1, 0,
                    11, 16'h004E, 6, 0, 1'b1, 16'd2);
        tbl[2] = mk("starve", 4, -1, -1, 2, 3, -1, 0,
                    11, 16'h0072, 4, 0, 1'b0, ZF ? 16'd0 : 16'd1);
        tbl[3] = mk("len0", 0, -1, -1, -1, -1, -1, 0,
                    1, 16'h0000, 0, 0, 1'b0, 16'd0);
        tbl[4] = mk("bstart", 4, -1, -1, -1, -1, 3, 7,
                    9, 16'h001E, 8, 2, 1'b1, 16'd24);

        do_reset();
        cmp("rst_busy", 0, 64'(busy), 64'(0));
        cmp("rst_done", 0, 64'(done), 64'(0));
        cmp("rst_ren", 0, 64'(fifo_ren), 64'(0));
        cmp("rst_val", 0, 64'(arr_val), 64'(0));
        cmp("rst_data", 0, 64'(arr_data), 64'(0));

        for (int t = 0; t < 5; t++) begin
            logic [15:0] m;
            int fd;
            int nd;
            do_reset();
            clear_stim();
            for (int i = 0; i < NL; i++)
                for (int k = 1; k <= 8; k++)
                    fq[i].push_back(NB'(i * 10 + k));
            st_start[0] = 1'b1;
            st_len[0] = LW'(tbl[t].len);
            if (tbl[t].st_lo >= 0)
                for (int c = tbl[t].st_lo; c <= tbl[t].st_hi; c++)
                    st_stall[c] = 1'b1;
            if (tbl[t].sv_lo >= 0)
                for (int c = tbl[t].sv_lo; c <= tbl[t].sv_hi; c++)
                    st_force[c][1] = 1'b1;
            if (tbl[t].s2_cyc >= 0) begin
                st_start[tbl[t].s2_cyc] = 1'b1;
                st_len[tbl[t].s2_cyc] = LW'(tbl[t].s2_len);
            end
            build_model(20);
            run(20);
            compare_all(20, tbl[t].name);
            m = '0;
            for (int c = 0; c < 16; c++) m[c] = l_ren[c][0];
            cmp({tbl[t].name, "_renmask"}, 0, 64'(m), 64'(tbl[t].exp_ren));
            fd = -1;
            nd = 0;
            for (int c = 0; c < 20; c++) begin
                if (l_done[c]) begin
                    nd++;
                    if (fd < 0) fd = c;
                end
            end
            cmp({tbl[t].name, "_donecyc"}, fd, 64'(fd),
                64'(tbl[t].exp_done));
            cmp({tbl[t].name, "_donecnt"}, fd, 64'(nd), 64'(1));
            cmp({tbl[t].name, "_chkval"}, tbl[t].chk_c,
                64'(l_val[tbl[t].chk_c][tbl[t].chk_lane]),
                64'(tbl[t].chk_v));
            cmp({tbl[t].name, "_chkdata"}, tbl[t].chk_c,
                64'(l_data[tbl[t].chk_c][tbl[t].chk_lane*NB +: NB]),
                64'(tbl[t].chk_d));
        end

        // Asynchronous reset in the middle of a block.
        begin
            int nd;
            logic [NB-1:0] got [NL][$];
            do_reset();
            for (int i = 0; i < NL; i++)
                for (int k = 1; k <= 8; k++)
                    fq[i].push_back(NB'(i * 10 + k));
            start = 1'b1;
            len = 8'd4;
            drive_empty('0);
            tick();
            start = 1'b0;
            drive_empty('0);
            tick();
            drive_empty('0);
            tick();
            rst = 1'b0;
            #1;
            cmp("arst_busy", 3, 64'(busy), 64'(0));
            cmp("arst_done", 3, 64'(done), 64'(0));
            cmp("arst_ren", 3, 64'(fifo_ren), 64'(0));
            cmp("arst_val", 3, 64'(arr_val), 64'(0));
            cmp("arst_data", 3, 64'(arr_data), 64'(0));
            #1;
            rst = 1'b1;
            for (int c = 0; c < 3; c++) begin
                drive_empty('0);
                tick();
                cmp("arst_nodone", c, 64'(s_done), 64'(0));
                cmp("arst_idle", c, 64'(s_busy), 64'(0));
            end
            start = 1'b1;
            len = 8'd2;
            nd = 0;
            for (int c = 0; c < 12; c++) begin
                drive_empty('0);
                tick();
                start = 1'b0;
                if (s_done) nd++;
                for (int i = 0; i < NL; i++)
                    if (s_val[i]) got[i].push_back(s_data[i*NB +: NB]);
            end
            cmp("arst2_donecnt", 0, 64'(nd), 64'(1));
            for (int i = 0; i < NL; i++) begin
                cmp("arst2_nwords", i, 64'(got[i].size()), 64'(2));
                if (got[i].size() == 2) begin
                    cmp("arst2_w0", i, 64'(got[i][0]), 64'(i * 10 + 3));
                    cmp("arst2_w1", i, 64'(got[i][1]), 64'(i * 10 + 4));
                end
            end
        end

        // Random blocks, stalls, starvation and stray starts.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            clear_stim();
            for (int i = 0; i < NL; i++)
                for (int k = 0; k < 30; k++)
                    fq[i].push_back(NB'($urandom));
            for (int c = 0; c < 60; c++) begin
                st_start[c] = ($urandom % 6) == 0;
                st_len[c]   = LW'($urandom_range(0, 5));
                st_stall[c] = ($urandom % 5) == 0;
                for (int i = 0; i < NL; i++)
                    st_force[c][i] = ($urandom % 7) == 0;
            end
            build_model(60);
            run(60);
            compare_all(60, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
